dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (dmem: async read, posedge write, 64 words, word index a[31:2])

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_pick.sv | 29 ++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants for the data-memory arbiter.
//   State encoding for the serialising FSM, requester ids and
//   arbitration-mode selectors used by dmem_arbiter and dmem_arb_pick.
package dmem_arb_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StServe = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

  localparam int unsigned ArbRr    = 0;
  localparam int unsigned ArbFixed = 1;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select for the two dmem requesters.
//   i_req0/i_req1  request levels of port 0 / port 1
//   i_last_grant   port granted most recently (round-robin pointer)
//   o_valid        at least one request present
//   o_grant        winning port id (only meaningful with o_valid)
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE = ArbRr
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_grant
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = Port0;
    if (i_req0 && i_req1) begin
      // Tie: fixed mode favours port 0, round-robin favours the port not served last.
      o_grant = (ARB_MODE == ArbFixed) ? Port0 : ~i_last_grant;
    end else if (i_req1) begin
      o_grant = Port1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port dmem between the core (port 0) and a
// debug/DMA loader (port 1). One access per three cycles: IDLE -> SERVE -> DONE.
//   clk, reset           clock, asynchronous active-high reset
//   pX_req/we/addr/wdata requester X command, held stable until pX_ack
//   pX_rdata/ack/err     registered response, ack/err pulse for one cycle
//   mem_we/mem_a/mem_wd  drive to dmem, mem_rd async read data back
//   busy                 high while an access is in SERVE or DONE
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned ARB_MODE  = ArbRr
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_sel;
  logic              r_last_grant;
  logic              w_valid;
  logic              w_grant;
  logic              w_grant_en;
  logic              w_serve;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [ADDR_W-1:0] w_word_idx;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_done0;
  logic              w_done1;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic              r_p0_ack;
  logic              r_p1_ack;
  logic              r_p0_err;
  logic              r_p1_err;

  dmem_arb_pick #(
    .ARB_MODE(ARB_MODE)
  ) u_pick (
    .i_req0      (p0_req),
    .i_req1      (p1_req),
    .i_last_grant(r_last_grant),
    .o_valid     (w_valid),
    .o_grant     (w_grant)
  );

  assign w_grant_en = (r_state == StIdle) & w_valid;
  assign w_serve    = (r_state == StServe);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_valid) w_state_next = StServe;
      StServe: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Last grant resets to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_sel        <= Port0;
      r_last_grant <= Port1;
    end else begin
      r_state <= w_state_next;
      if (w_grant_en) begin
        r_sel        <= w_grant;
        r_last_grant <= w_grant;
      end
    end
  end

  // Port mux follows the latched selection, so the other port's inputs are don't-care.
  assign w_sel_we    = (r_sel == Port1) ? p1_we    : p0_we;
  assign w_sel_addr  = (r_sel == Port1) ? p1_addr  : p0_addr;
  assign w_sel_wdata = (r_sel == Port1) ? p1_wdata : p0_wdata;

  assign w_word_idx = {2'b00, w_sel_addr[ADDR_W-1:2]};
  assign w_in_range = (w_word_idx < ADDR_W'(MEM_WORDS));

  // Purely combinational from r_state, so an async reset kills a pending write at once.
  assign mem_we = w_serve & w_sel_we & w_in_range;
  assign mem_a  = w_serve ? w_sel_addr  : '0;
  assign mem_wd = w_serve ? w_sel_wdata : '0;
  assign busy   = (r_state != StIdle);

  assign w_rd_val = w_in_range ? mem_rd : '0;
  assign w_done0  = w_serve & (r_sel == Port0);
  assign w_done1  = w_serve & (r_sel == Port1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p1_err   <= 1'b0;
    end else begin
      r_p0_ack <= w_done0;
      r_p1_ack <= w_done1;
      r_p0_err <= w_done0 & ~w_in_range;
      r_p1_err <= w_done1 & ~w_in_range;
      if (w_done0) r_p0_rdata <= w_rd_val;
      if (w_done1) r_p1_rdata <= w_rd_val;
    end
  end

  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;
  assign p0_ack   = r_p0_ack;
  assign p1_ack   = r_p1_ack;
  assign p0_err   = r_p0_err;
  assign p1_err   = r_p1_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiter instances, round-robin (rr_*) with a writable dmem
// model and fixed priority (fx_*) with a read-only pattern memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        rr_p0_req, rr_p0_we, rr_p1_req, rr_p1_we;
  logic [31:0] rr_p0_addr, rr_p0_wdata, rr_p1_addr, rr_p1_wdata;
  logic [31:0] rr_p0_rdata, rr_p1_rdata;
  logic        rr_p0_ack, rr_p0_err, rr_p1_ack, rr_p1_err;
  logic        rr_mem_we, rr_busy;
  logic [31:0] rr_mem_a, rr_mem_wd, rr_mem_rd;

  logic        fx_p0_req, fx_p0_we, fx_p1_req, fx_p1_we;
  logic [31:0] fx_p0_addr, fx_p0_wdata, fx_p1_addr, fx_p1_wdata;
  logic [31:0] fx_p0_rdata, fx_p1_rdata;
  logic        fx_p0_ack, fx_p0_err, fx_p1_ack, fx_p1_err;
  logic        fx_mem_we, fx_busy;
  logic [31:0] fx_mem_a, fx_mem_wd, fx_mem_rd;

  // dmem: async read, posedge write, index wraps on a[7:2]
  logic [31:0] mem_rr [64] = '{default: '0};
  assign rr_mem_rd = mem_rr[rr_mem_a[7:2]];
  always @(posedge clk) if (rr_mem_we) mem_rr[rr_mem_a[7:2]] <= rr_mem_wd;

  assign fx_mem_rd = 32'hC0DE_0000 | {26'd0, fx_mem_a[7:2]};

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(64), .ARB_MODE(0)) u_rr (
    .clk(clk), .reset(reset),
    .p0_req(rr_p0_req), .p0_we(rr_p0_we), .p0_addr(rr_p0_addr), .p0_wdata(rr_p0_wdata),
    .p0_rdata(rr_p0_rdata), .p0_ack(rr_p0_ack), .p0_err(rr_p0_err),
    .p1_req(rr_p1_req), .p1_we(rr_p1_we), .p1_addr(rr_p1_addr), .p1_wdata(rr_p1_wdata),
    .p1_rdata(rr_p1_rdata), .p1_ack(rr_p1_ack), .p1_err(rr_p1_err),
    .mem_we(rr_mem_we), .mem_a(rr_mem_a), .mem_wd(rr_mem_wd), .mem_rd(rr_mem_rd),
    .busy(rr_busy)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(64), .ARB_MODE(1)) u_fx (
    .clk(clk), .reset(reset),
    .p0_req(fx_p0_req), .p0_we(fx_p0_we), .p0_addr(fx_p0_addr), .p0_wdata(fx_p0_wdata),
    .p0_rdata(fx_p0_rdata), .p0_ack(fx_p0_ack), .p0_err(fx_p0_err),
    .p1_req(fx_p1_req), .p1_we(fx_p1_we), .p1_addr(fx_p1_addr), .p1_wdata(fx_p1_wdata),
    .p1_rdata(fx_p1_rdata), .p1_ack(fx_p1_ack), .p1_err(fx_p1_err),
    .mem_we(fx_mem_we), .mem_a(fx_mem_a), .mem_wd(fx_mem_wd), .mem_rd(fx_mem_rd),
    .busy(fx_busy)
  );

  // Reference model of the round-robin instance.
  logic [31:0] ref_mem [64];
  logic        m_last;
  logic [31:0] m_rd [2];
  bit          m_rd_ok [2];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic model_reset;
    m_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_rd[i]    = 32'h0;
      m_rd_ok[i] = 1'b1;
    end
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One transaction round on the rr instance: predicts grant order, ack cycles,
  // err/rdata and memory effect from the arbitration rules, then watches 7 cycles.
  task automatic do_txn(input string name, input logic r0, input logic r1,
                        input logic we0, input logic we1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
    logic        we [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    bit          srv [2];
    bit          got [2];
    int          exp_cyc [2];
    logic        exp_err [2];
    int          order [2];
    int          n_srv;
    int          exp_we;
    int          we_cyc;
    logic        ack;
    logic        err;
    logic [31:0] rd;
    we[0] = we0; we[1] = we1; ad[0] = a0; ad[1] = a1; wd[0] = d0; wd[1] = d1;
    srv[0] = r0; srv[1] = r1;
    for (int p = 0; p < 2; p++) begin
      got[p] = 1'b0; exp_cyc[p] = -1; exp_err[p] = 1'b0; order[p] = 0;
    end
    n_srv = 0;
    if (r0 && r1) begin
      order[0] = (m_last == 1'b0) ? 1 : 0;
      order[1] = 1 - order[0];
      n_srv = 2;
    end else if (r0 || r1) begin
      order[0] = r0 ? 0 : 1;
      n_srv = 1;
    end
    exp_we = 0;
    for (int k = 0; k < n_srv; k++) begin
      int          p;
      int unsigned idx;
      p = order[k];
      idx = ad[p] >> 2;
      exp_cyc[p] = 2 + 3 * k;
      exp_err[p] = (idx >= 64);
      m_rd_ok[p] = !(we[p] && idx >= 64);
      m_rd[p] = (idx < 64) ? ref_mem[idx] : 32'h0;
      if (we[p] && idx < 64) begin
        ref_mem[idx] = wd[p];
        exp_we++;
      end
      m_last = p[0];
    end

    @(negedge clk);
    rr_p0_req = r0; rr_p0_we = we0; rr_p0_addr = a0; rr_p0_wdata = d0;
    rr_p1_req = r1; rr_p1_we = we1; rr_p1_addr = a1; rr_p1_wdata = d1;
    we_cyc = 0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (rr_mem_we) we_cyc++;
      if (c == 1 && n_srv > 0) begin
        n_checks++;
        if (rr_busy !== 1'b1) $display("FAIL %s busy_in_serve: got %b want 1", name, rr_busy);
        else n_pass++;
      end
      for (int p = 0; p < 2; p++) begin
        ack = p ? rr_p1_ack : rr_p0_ack;
        err = p ? rr_p1_err : rr_p0_err;
        rd  = p ? rr_p1_rdata : rr_p0_rdata;
        if (ack || err) begin
          n_checks++;
          if (!srv[p] || got[p] || !ack || c != exp_cyc[p])
            $display("FAIL %s p%0d_ack: ack=%b err=%b at cycle %0d, want ack at cycle %0d",
                     name, p, ack, err, c, exp_cyc[p]);
          else n_pass++;
          got[p] = 1'b1;
          n_checks++;
          if (err !== exp_err[p])
            $display("FAIL %s p%0d_err: got %b want %b", name, p, err, exp_err[p]);
          else n_pass++;
          if (m_rd_ok[p]) begin
            n_checks++;
            if (rd !== m_rd[p])
              $display("FAIL %s p%0d_rdata: got %h want %h", name, p, rd, m_rd[p]);
            else n_pass++;
          end
          if (p == 0) rr_p0_req = 1'b0;
          else rr_p1_req = 1'b0;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      rd = p ? rr_p1_rdata : rr_p0_rdata;
      if (srv[p]) begin
        n_checks++;
        if (!got[p]) $display("FAIL %s p%0d_no_ack: got none want ack at cycle %0d",
                              name, p, exp_cyc[p]);
        else n_pass++;
      end
      if (m_rd_ok[p]) begin
        n_checks++;
        if (rd !== m_rd[p]) $display("FAIL %s p%0d_rdata_hold: got %h want %h",
                                     name, p, rd, m_rd[p]);
        else n_pass++;
      end
    end
    n_checks++;
    if (we_cyc != exp_we) $display("FAIL %s mem_we_cycles: got %0d want %0d", name, we_cyc, exp_we);
    else n_pass++;
    n_checks++;
    if ({rr_busy, rr_mem_we, rr_mem_a, rr_mem_wd} !== 66'd0)
      $display("FAIL %s idle_outputs: busy=%b we=%b a=%h wd=%h want all 0",
               name, rr_busy, rr_mem_we, rr_mem_a, rr_mem_wd);
    else n_pass++;
    rr_p0_req = 1'b0;
    rr_p1_req = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({rr_p0_ack, rr_p0_err, rr_p1_ack, rr_p1_err, rr_mem_we, rr_busy} !== 6'd0)
      $display("FAIL reset_rr_flags: got %b want 000000",
               {rr_p0_ack, rr_p0_err, rr_p1_ack, rr_p1_err, rr_mem_we, rr_busy});
    else n_pass++;
    n_checks++;
    if ({rr_p0_rdata, rr_p1_rdata} !== 64'd0)
      $display("FAIL reset_rr_rdata: got %h %h want 0", rr_p0_rdata, rr_p1_rdata);
    else n_pass++;
    n_checks++;
    if ({rr_mem_a, rr_mem_wd} !== 64'd0)
      $display("FAIL reset_rr_mem: a=%h wd=%h want 0", rr_mem_a, rr_mem_wd);
    else n_pass++;
    n_checks++;
    if ({fx_p0_ack, fx_p0_err, fx_p1_ack, fx_p1_err, fx_mem_we, fx_busy} !== 6'd0)
      $display("FAIL reset_fx_flags: got %b want 000000",
               {fx_p0_ack, fx_p0_err, fx_p1_ack, fx_p1_err, fx_mem_we, fx_busy});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if ({rr_busy, rr_p0_ack, rr_p1_ack} !== 3'd0)
      $display("FAIL reset_release_idle: busy/ack got %b want 000", {rr_busy, rr_p0_ack, rr_p1_ack});
    else n_pass++;
  endtask

  task automatic test_store_load;
    do_txn("store_p0", 1'b1, 1'b0, 1'b1, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 32'h0);
    do_txn("load_p0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (m_rd[0] !== 32'hDEAD_BEEF) $display("FAIL load_p0_model: got %h want deadbeef", m_rd[0]);
    else n_pass++;
  endtask

  task automatic test_rr_tie;
    apply_reset();
    do_txn("rr_tie_1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h08, 32'h10, 32'h0, 32'h0);
    do_txn("rr_tie_2", 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h08, 32'h0, 32'h0);
    do_txn("rr_tie_3", 1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h20, 32'h1111_1111, 32'h2222_2222);
  endtask

  task automatic test_fixed_priority;
    int acks;
    int we_cyc;
    bit p1_seen;
    bit p1_got;
    @(negedge clk);
    fx_p0_req = 1'b1; fx_p0_we = 1'b0; fx_p0_addr = 32'h14;
    fx_p1_req = 1'b1; fx_p1_we = 1'b0; fx_p1_addr = 32'h18;
    acks = 0; p1_seen = 1'b0; we_cyc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (fx_p1_ack) p1_seen = 1'b1;
      if (fx_mem_we) we_cyc++;
      if (fx_p0_ack) begin
        n_checks++;
        if (c != 2 + 3 * acks) $display("FAIL fixed_p0_period: ack at cycle %0d want %0d",
                                        c, 2 + 3 * acks);
        else n_pass++;
        n_checks++;
        if (fx_p0_rdata !== 32'hC0DE_0005)
          $display("FAIL fixed_p0_rdata: got %h want c0de0005", fx_p0_rdata);
        else n_pass++;
        acks++;
        fx_p0_req = 1'b0;
      end else if (!fx_p0_req) begin
        fx_p0_req = 1'b1;
      end
    end
    n_checks++;
    if (acks != 5) $display("FAIL fixed_p0_count: got %0d acks want 5", acks);
    else n_pass++;
    n_checks++;
    if (p1_seen) $display("FAIL fixed_p1_starve: got p1 ack want none");
    else n_pass++;
    p1_got = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (fx_mem_we) we_cyc++;
      if (fx_p1_ack && !p1_got) begin
        p1_got = 1'b1;
        n_checks++;
        if (c != 3 || fx_p1_rdata !== 32'hC0DE_0006)
          $display("FAIL fixed_p1_serve: cycle %0d rdata %h want cycle 3 rdata c0de0006",
                   c, fx_p1_rdata);
        else n_pass++;
        fx_p1_req = 1'b0;
      end
    end
    n_checks++;
    if (!p1_got) $display("FAIL fixed_p1_no_ack: got none want ack after p0 stops");
    else n_pass++;
    n_checks++;
    if (we_cyc != 0 || {fx_mem_a, fx_mem_wd} !== 64'd0)
      $display("FAIL fixed_mem_idle: we_cycles %0d a=%h wd=%h want 0", we_cyc, fx_mem_a, fx_mem_wd);
    else n_pass++;
    fx_p1_req = 1'b0;
  endtask

  task automatic test_out_of_range;
    do_txn("oor_prep", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 32'h0);
    do_txn("oor_store", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h100, 32'h0, 32'hFFFF_FFFF);
    n_checks++;
    if (mem_rr[0] !== 32'h1234_5678)
      $display("FAIL oor_word0: got %h want 12345678", mem_rr[0]);
    else n_pass++;
    do_txn("oor_load", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h104, 32'h0, 32'h0);
    do_txn("oor_load_top", 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_random;
    logic        r0, r1, we0, we1;
    logic [31:0] a [2];
    logic [31:0] d [2];
    for (int it = 0; it < 30; it++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 7) == 0) a[p] = (32'($urandom_range(64, 1023)) << 2);
        else a[p] = (32'($urandom_range(0, 7)) << 2);
        a[p] = a[p] | 32'($urandom_range(0, 3));
        d[p] = $urandom;
      end
      do_txn("random", r0, r1, we0, we1, a[0], a[1], d[0], d[1]);
    end
  endtask

  task automatic test_reset_mid_serve;
    @(negedge clk);
    rr_p0_req = 1'b1; rr_p0_we = 1'b1; rr_p0_addr = 32'h0C; rr_p0_wdata = 32'hBAD0_C0DE;
    @(posedge clk);
    #1;
    n_checks++;
    if (rr_mem_we !== 1'b1) $display("FAIL midrst_we_before: got %b want 1", rr_mem_we);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({rr_mem_we, rr_busy} !== 2'b00)
      $display("FAIL midrst_we_drop: we/busy got %b want 00", {rr_mem_we, rr_busy});
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({rr_p0_ack, rr_p1_ack, rr_mem_we} !== 3'b000)
        $display("FAIL midrst_no_ack: ack/we got %b want 000", {rr_p0_ack, rr_p1_ack, rr_mem_we});
      else n_pass++;
    end
    @(negedge clk);
    rr_p0_req = 1'b0;
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (mem_rr[3] !== ref_mem[3]) $display("FAIL midrst_word: got %h want %h", mem_rr[3], ref_mem[3]);
    else n_pass++;
    do_txn("tie_after_reset", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h08, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    model_reset();
    rr_p0_req = 1'b0; rr_p0_we = 1'b0; rr_p0_addr = '0; rr_p0_wdata = '0;
    rr_p1_req = 1'b0; rr_p1_we = 1'b0; rr_p1_addr = '0; rr_p1_wdata = '0;
    fx_p0_req = 1'b0; fx_p0_we = 1'b0; fx_p0_addr = '0; fx_p0_wdata = '0;
    fx_p1_req = 1'b0; fx_p1_we = 1'b0; fx_p1_addr = '0; fx_p1_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_store_load();
    test_rr_tie();
    test_fixed_priority();
    test_out_of_range();
    test_random();
    test_reset_mid_serve();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
